imem_sync: RTL and testbench
============================

IMEM_SYNC -- requirements
Module: imem_sync

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit instruction words; power of two, 8..1024.
REQ-002 Parameter PRELOAD, default 1, when 1 reset loads the built-in R-type test program.
REQ-003 Parameter CNT_W, default 16, width of the fetch performance counter.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 fetch_req  in  1  fetch request, sampled each cycle.
REQ-007 stall  in  1  downstream stall; freezes the output stage.
REQ-008 PC  in  32  byte address of the requested instruction.
REQ-009 prog_mode  in  1  program-load mode; fetches are blocked while high.
REQ-010 prog_we  in  1  write strobe for the program port; honoured only while prog_mode=1.
REQ-011 prog_addr  in  32  byte address of the program write.
REQ-012 prog_data  in  32  instruction word to write.
REQ-013 instruction_code  out  32  registered fetched instruction.
REQ-014 instr_valid  out  1  instruction_code holds a valid fetch result this cycle.
REQ-015 fault  out  1  the registered fetch was misaligned or out of range.
REQ-016 fetch_count  out  CNT_W  number of accepted fetches, saturating.

Function
REQ-017 Word index is PC[log2(DEPTH)+1:2]; in-range means PC < 4*DEPTH.
REQ-018 A fetch is accepted when fetch_req=1, stall=0 and prog_mode=0.
REQ-019 Read latency is exactly 1 cycle: an accepted fetch at edge N drives instruction_code/instr_valid/fault after edge N.
REQ-020 Accepted, aligned (PC[1:0]=0) and in-range fetch -> instruction_code=Memory[index], instr_valid=1, fault=0.
REQ-021 Accepted fetch that is misaligned or out of range -> instruction_code=32'h00000013 (NOP), instr_valid=1, fault=1; the memory is not read.
REQ-022 stall=1 -> instruction_code, instr_valid and fault hold their values; no fetch is accepted.
REQ-023 stall=0 and no accepted fetch -> instr_valid=0, fault=0, instruction_code=NOP.
REQ-024 prog_mode=1 and prog_we=1 with aligned, in-range prog_addr -> Memory[prog_addr index]<=prog_data at the edge.
REQ-025 Program writes that are misaligned or out of range are dropped silently; the memory is unchanged.
REQ-026 prog_mode=1 blocks fetches, so writes and reads never collide; the first fetch after prog_mode falls observes all completed writes.
REQ-027 fetch_count increments by 1 per accepted fetch, faulting fetches included, and saturates at 2^CNT_W-1.
REQ-028 prog_mode rising while an output is held under stall keeps that held output until stall falls.

Reset
REQ-029 reset=1 immediately forces instruction_code=NOP, instr_valid=0, fault=0, fetch_count=0.
REQ-030 PRELOAD=1: reset loads words 0..6 = 00940333, 413903b3, 017b4e33, 00f768b3, 00d67fb3, 019c1eb3, 01bd5f33 and all other words = 00000013.
REQ-031 PRELOAD=0: reset loads every word with 00000013.
REQ-032 Reset asserted mid-fetch or mid-write discards that operation; the first accepted fetch after release completes with normal 1-cycle latency.

Verification
REQ-033 Reset, then fetches with PC=0,4,...,24 back-to-back -> from the next cycle, one word per cycle: 00940333 .. 01bd5f33, instr_valid=1, fault=0, fetch_count=7.
REQ-034 Fetch PC=2, then PC=4*DEPTH -> instruction_code=00000013, fault=1 on both cycles, instr_valid=1.
REQ-035 Fetch PC=8, stall=1 for 3 cycles -> 017b4e33 held for 3 cycles, fetch_count unchanged during the stall.
REQ-036 prog_mode=1, write 0xDEADBEEF at prog_addr 40, with fetch_req=1 throughout -> instr_valid=0 during prog_mode; after prog_mode=0, fetch of PC=40 returns DEADBEEF.
REQ-037 CNT_W=4, 20 accepted fetches -> fetch_count=15.
REQ-038 Assert reset mid-stream while a valid instruction is output -> instr_valid=0 and instruction_code=00000013 at once; words written through the program port read back as preload values.

Source files
------------

// File: rtl/imem_sync_if.sv
// Fetch and program-load bus for the synchronous instruction memory.
// master drives requests; slave returns the registered fetch result.
interface imem_sync_if #(
  parameter int CNT_W = 16
);
  logic             fetch_req;
  logic             stall;
  logic [31:0]      PC;
  logic             prog_mode;
  logic             prog_we;
  logic [31:0]      prog_addr;
  logic [31:0]      prog_data;
  logic [31:0]      instruction_code;
  logic             instr_valid;
  logic             fault;
  logic [CNT_W-1:0] fetch_count;

  modport master (
    output fetch_req, stall, PC,
    output prog_mode, prog_we,
    output prog_addr, prog_data,
    input  instruction_code,
    input  instr_valid, fault,
    input  fetch_count
  );

  modport slave (
    input  fetch_req, stall, PC,
    input  prog_mode, prog_we,
    input  prog_addr, prog_data,
    output instruction_code,
    output instr_valid, fault,
    output fetch_count
  );
endinterface

// File: rtl/imem_sync.sv
// Instruction memory with registered 1-cycle fetch, program port,
// fault flagging and a saturating fetch counter.
module imem_sync #(
  parameter int DEPTH   = 64,
  parameter int PRELOAD = 1,
  parameter int CNT_W   = 16
) (
  input logic         clk,
  input logic         reset,
  imem_sync_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]      mem [DEPTH];
  logic [31:0]      code_q;
  logic             valid_q;
  logic             fault_q;
  logic [CNT_W-1:0] cnt_q;

  logic          accept;
  logic          rd_ok;
  logic          wr_ok;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;

  function automatic logic [31:0] boot_word(int i);
    logic [31:0] w;
    w = NOP;
    if (PRELOAD == 1) begin
      unique case (i)
        0: w = 32'h0094_0333;
        1: w = 32'h4139_03b3;
        2: w = 32'h017b_4e33;
        3: w = 32'h00f7_68b3;
        4: w = 32'h00d6_7fb3;
        5: w = 32'h019c_1eb3;
        6: w = 32'h01bd_5f33;
        default: w = NOP;
      endcase
    end
    return w;
  endfunction

  assign accept = bus.fetch_req
                & ~bus.stall
                & ~bus.prog_mode;
  assign rd_idx = bus.PC[AW+1:2];
  assign wr_idx = bus.prog_addr[AW+1:2];

  // Aligned and below 4*DEPTH: upper bits must all be zero.
  assign rd_ok = (bus.PC[1:0] == 2'b00)
               && (bus.PC[31:AW+2] == '0);
  assign wr_ok = bus.prog_mode & bus.prog_we
               && (bus.prog_addr[1:0] == 2'b00)
               && (bus.prog_addr[31:AW+2] == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= boot_word(i);
    end else if (wr_ok) begin
      mem[wr_idx] <= bus.prog_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_q  <= NOP;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (!bus.stall) begin
        if (accept && rd_ok) begin
          code_q  <= mem[rd_idx];
          valid_q <= 1'b1;
          fault_q <= 1'b0;
        end else if (accept) begin
          code_q  <= NOP;
          valid_q <= 1'b1;
          fault_q <= 1'b1;
        end else begin
          code_q  <= NOP;
          valid_q <= 1'b0;
          fault_q <= 1'b0;
        end
      end
      if (accept && (cnt_q != '1))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.instruction_code = code_q;
  assign bus.instr_valid      = valid_q;
  assign bus.fault            = fault_q;
  assign bus.fetch_count      = cnt_q;
endmodule

// File: tb/tb_imem_sync.sv
// Table-driven bench for imem_sync with an expected-result queue;
// a second instance with a 4-bit counter checks saturation.
module tb_imem_sync;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        req;
    logic        stl;
    logic        pm;
    logic        we;
    logic [31:0] pc;
    logic [31:0] pa;
    logic [31:0] pd;
    logic [31:0] code;
    logic        valid;
    logic        flt;
    int          cnt;
  } vec_t;

  typedef struct {
    logic [31:0] code;
    logic        valid;
    logic        flt;
    int          cnt;
  } exp_t;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  exp_t sb [$];
  vec_t tbl [$];

  imem_sync_if #(.CNT_W(16)) bus ();
  imem_sync_if #(.CNT_W(4))  bus4 ();

  imem_sync #(.DEPTH(64), .PRELOAD(1), .CNT_W(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  imem_sync #(.DEPTH(64), .PRELOAD(1), .CNT_W(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  assign bus4.fetch_req = bus.fetch_req;
  assign bus4.stall     = bus.stall;
  assign bus4.PC        = bus.PC;
  assign bus4.prog_mode = bus.prog_mode;
  assign bus4.prog_we   = bus.prog_we;
  assign bus4.prog_addr = bus.prog_addr;
  assign bus4.prog_data = bus.prog_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1);
  end

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] req);
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: act=%h req=%h", nm, act, req);
    end
  endtask

  task automatic compare_all(exp_t e);
    int c4;
    c4 = (e.cnt > 15) ? 15 : e.cnt;
    chk("code", bus.instruction_code, e.code);
    chk("valid", 32'(bus.instr_valid), 32'(e.valid));
    chk("fault", 32'(bus.fault), 32'(e.flt));
    chk("count", 32'(bus.fetch_count), 32'(e.cnt));
    chk("count4", 32'(bus4.fetch_count), 32'(c4));
  endtask

  task automatic drive(vec_t v);
    bus.fetch_req = v.req;
    bus.stall     = v.stl;
    bus.PC        = v.pc;
    bus.prog_mode = v.pm;
    bus.prog_we   = v.we;
    bus.prog_addr = v.pa;
    bus.prog_data = v.pd;
  endtask

  task automatic step(vec_t v);
    exp_t e;
    @(negedge clk);
    drive(v);
    e.code  = v.code;
    e.valid = v.valid;
    e.flt   = v.flt;
    e.cnt   = v.cnt;
    sb.push_back(e);
    n_vec++;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL queue: act=empty req=entry");
    end else begin
      compare_all(sb.pop_front());
    end
  endtask

  function automatic vec_t mk(
    logic req, logic stl, logic pm, logic we,
    logic [31:0] pc, logic [31:0] pa, logic [31:0] pd,
    logic [31:0] code, logic valid, logic flt, int cnt);
    vec_t v;
    v.req = req; v.stl = stl; v.pm = pm; v.we = we;
    v.pc = pc; v.pa = pa; v.pd = pd;
    v.code = code; v.valid = valid; v.flt = flt;
    v.cnt = cnt;
    return v;
  endfunction

  function automatic vec_t fe(logic [31:0] pc,
    logic [31:0] code, logic flt, int cnt);
    return mk(1, 0, 0, 0, pc, 0, 0, code, 1, flt, cnt);
  endfunction

  logic [31:0] boot [7];
  exp_t        er;

  initial begin
    n_vec = 0;
    n_err = 0;
    boot[0] = 32'h0094_0333;
    boot[1] = 32'h4139_03b3;
    boot[2] = 32'h017b_4e33;
    boot[3] = 32'h00f7_68b3;
    boot[4] = 32'h00d6_7fb3;
    boot[5] = 32'h019c_1eb3;
    boot[6] = 32'h01bd_5f33;

    for (int i = 0; i < 7; i++)
      tbl.push_back(fe(32'(4*i), boot[i], 0, i+1));
    tbl.push_back(mk(0,0,0,0, 0,0,0, NOP,0,0, 7));
    tbl.push_back(fe(32'd2,   NOP, 1, 8));
    tbl.push_back(fe(32'd256, NOP, 1, 9));
    tbl.push_back(fe(32'd8, boot[2], 0, 10));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1,1,0,0, 0,0,0,
                       boot[2],1,0, 10));
    tbl.push_back(mk(0,0,0,0, 0,0,0, NOP,0,0, 10));
    tbl.push_back(mk(1,0,1,1, 40,40,32'hDEADBEEF,
                     NOP,0,0, 10));
    tbl.push_back(mk(1,0,1,1, 40,42,32'h1111_1111,
                     NOP,0,0, 10));
    tbl.push_back(mk(1,0,1,1, 40,264,32'h2222_2222,
                     NOP,0,0, 10));
    tbl.push_back(mk(0,0,0,1, 0,12,32'h3333_3333,
                     NOP,0,0, 10));
    tbl.push_back(fe(32'd40, 32'hDEADBEEF, 0, 11));
    tbl.push_back(fe(32'd8,  boot[2], 0, 12));
    tbl.push_back(fe(32'd12, boot[3], 0, 13));
    tbl.push_back(fe(32'd28,  NOP, 0, 14));
    tbl.push_back(fe(32'd252, NOP, 0, 15));
    tbl.push_back(fe(32'd1,   NOP, 1, 16));
    tbl.push_back(fe(32'd4, boot[1], 0, 17));
    tbl.push_back(mk(1,1,1,0, 0,0,0, boot[1],1,0, 17));
    tbl.push_back(mk(1,1,1,0, 0,0,0, boot[1],1,0, 17));
    tbl.push_back(mk(1,0,1,0, 0,0,0, NOP,0,0, 17));
    tbl.push_back(fe(32'd0,  boot[0], 0, 18));
    tbl.push_back(fe(32'd16, boot[4], 0, 19));
    tbl.push_back(fe(32'd20, boot[5], 0, 20));
    tbl.push_back(fe(32'd40, 32'hDEADBEEF, 0, 21));

    drive(mk(0,0,0,0, 0,0,0, NOP,0,0, 0));
    reset = 1'b1;
    #1;
    er.code = NOP; er.valid = 0; er.flt = 0; er.cnt = 0;
    n_vec++;
    compare_all(er);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) step(tbl[i]);

    // Reset lands while DEADBEEF is on the output.
    #1;
    reset = 1'b1;
    #1;
    n_vec++;
    compare_all(er);
    @(negedge clk);
    drive(mk(1,0,1,1, 0,0,32'hAAAA_AAAA, NOP,0,0, 0));
    @(posedge clk);
    #1;
    n_vec++;
    compare_all(er);
    @(negedge clk);
    reset = 1'b0;
    drive(mk(0,0,0,0, 0,0,0, NOP,0,0, 0));
    step(fe(32'd0,  boot[0], 0, 1));
    step(fe(32'd40, NOP,     0, 2));
    step(mk(0,0,0,0, 0,0,0, NOP,0,0, 2));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
